// File: rtl/load_store_unit.sv
// Load/store unit: aligns requests, drives a single-beat memory handshake and extends load data.
// Optional bus timeout when LSU_TIMEOUT_EN is defined (TIMEOUT_CYCLES sets the abort point).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Stall_o,
  output logic        Misaligned_o,
  output logic        Bus_Error_o,
  output logic        Mem_Req_o,
  output logic        Mem_We_o,
  output logic [31:0] Mem_Addr_o,
  output logic [31:0] Mem_Wdata_o,
  output logic [3:0]  Mem_Be_o,
  input  logic        Mem_Ack_i,
  input  logic [31:0] Mem_Rdata_i,
  output logic [1:0]  state_dbg
);

  // Memory handshake: Mem_Req_o is held with stable We/Addr/Wdata/Be until the
  // cycle Mem_Ack_i is high; that cycle completes the transfer. Ack elsewhere is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic        we_q, misaligned_q;
  logic        req, is_word, is_half, aligned, accept, misaligned, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, load_ext;

  assign req        = Mem_Read_i | Mem_Write_i;
  assign is_word    = Funct3_i[1];
  assign is_half    = (Funct3_i[1:0] == 2'b01);
  assign aligned    = is_word ? (Address_i[1:0] == 2'b00) :
                      is_half ? !Address_i[0] : 1'b1;
  assign accept     = (state_q == IDLE) && req && aligned;
  assign misaligned = (state_q == IDLE) && req && !aligned;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = Write_Data_i;
    if (!is_word && is_half) begin
      be_d    = 4'b0011 << Address_i[1:0];
      wdata_d = {2{Write_Data_i[15:0]}};
    end else if (!is_word) begin
      be_d    = 4'b0001 << Address_i[1:0];
      wdata_d = {4{Write_Data_i[7:0]}};
    end
  end

  // Lane select by byte offset; half accesses are aligned so the offset is 0 or 2.
  assign shifted = Mem_Rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    if (!f3_q[1] && f3_q[1:0] == 2'b01)
      load_ext = f3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    else if (!f3_q[1])
      load_ext = f3_q[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;

  assign timeout     = (state_q == ACCESS) && !Mem_Ack_i && (tmo_cnt == TMO_LAST);
  assign Bus_Error_o = bus_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt <= (state_q == ACCESS && !Mem_Ack_i) ? tmo_cnt + 1'b1 : '0;
      if (timeout) bus_err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout     = 1'b0;
  assign Bus_Error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  if (Mem_Ack_i || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      be_q         <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= misaligned;
      if (accept) begin
        addr_q  <= Address_i;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        f3_q    <= Funct3_i;
        we_q    <= Mem_Write_i;
      end
      if (misaligned) rdata_q <= '0;
      if (state_q == ACCESS && Mem_Ack_i && !we_q) rdata_q <= load_ext;
      else if (timeout) rdata_q <= '0;
    end
  end

  assign Stall_o      = accept || (state_q == ACCESS);
  assign Mem_Req_o    = (state_q == ACCESS);
  assign Mem_We_o     = we_q;
  assign Mem_Addr_o   = {addr_q[31:2], 2'b00};
  assign Mem_Wdata_o  = wdata_q;
  assign Mem_Be_o     = be_q;
  assign Read_Data_o  = rdata_q;
  assign Misaligned_o = misaligned_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment, reset abort and timeout behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Read_i, Mem_Write_i, Mem_Ack_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i, Write_Data_i, Mem_Rdata_i;
  logic [31:0] Read_Data_o, Mem_Addr_o, Mem_Wdata_o;
  logic        Stall_o, Misaligned_o, Bus_Error_o, Mem_Req_o, Mem_We_o;
  logic [3:0]  Mem_Be_o;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .Mem_Read_i(Mem_Read_i), .Mem_Write_i(Mem_Write_i),
    .Funct3_i(Funct3_i), .Address_i(Address_i), .Write_Data_i(Write_Data_i),
    .Read_Data_o(Read_Data_o), .Stall_o(Stall_o), .Misaligned_o(Misaligned_o),
    .Bus_Error_o(Bus_Error_o), .Mem_Req_o(Mem_Req_o), .Mem_We_o(Mem_We_o),
    .Mem_Addr_o(Mem_Addr_o), .Mem_Wdata_o(Mem_Wdata_o), .Mem_Be_o(Mem_Be_o),
    .Mem_Ack_i(Mem_Ack_i), .Mem_Rdata_i(Mem_Rdata_i), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Mem_Read_i = 1'b0; Mem_Write_i = 1'b0; Mem_Ack_i = 1'b0;
  endtask

  // One access: request, wait `delay` ACCESS cycles, ack, check DONE and return to IDLE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] mrd, input int delay,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int stalls;
    logic [31:0] exp_rd;
    stalls = 0;
    Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3; Address_i = addr; Write_Data_i = wd;
    #1;
    if (Stall_o) stalls++;
    check_val({tag, "_req_idle"}, 32'(Mem_Req_o), 32'd0);
    tick();
    check_val({tag, "_req"}, 32'(Mem_Req_o), 32'd1);
    check_val({tag, "_we"}, 32'(Mem_We_o), 32'(wr));
    check_val({tag, "_addr"}, Mem_Addr_o, {addr[31:2], 2'b00});
    check_val({tag, "_be"}, 32'(Mem_Be_o), 32'(exp_be));
    if (wr) check_val({tag, "_wdata"}, Mem_Wdata_o, exp_wd);
    for (int i = 0; i < delay; i++) begin
      if (Stall_o) stalls++;
      tick();
      check_val({tag, "_be_hold"}, 32'(Mem_Be_o), 32'(exp_be));
    end
    Mem_Ack_i = 1'b1; Mem_Rdata_i = mrd;
    #1;
    if (Stall_o) stalls++;
    tick();
    idle_inputs();
    #1;
    check_val({tag, "_done"}, 32'(state_dbg), 32'(S_DONE));
    check_val({tag, "_stall_done"}, 32'(Stall_o), 32'd0);
    check_val({tag, "_stalls"}, stalls, delay + 2);
    if (!wr && exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      check_val({tag, "_rdata"}, Read_Data_o, exp_rd);
    end
    tick();
    check_val({tag, "_idle"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    int cnt;
    idle_inputs();
    Funct3_i = 3'b010; Address_i = '0; Write_Data_i = '0; Mem_Rdata_i = '0;
    reset = 1'b0;
    tick(); tick();
    check_val("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check_val("rst_rdata", Read_Data_o, 32'd0);
    check_val("rst_req", 32'(Mem_Req_o), 32'd0);
    check_val("rst_be", 32'(Mem_Be_o), 32'd0);
    check_val("rst_addr", Mem_Addr_o, 32'd0);
    check_val("rst_berr", 32'(Bus_Error_o), 32'd0);
    reset = 1'b1;
    tick();

    exp_q.push_back(32'h8765_4321);
    run_access("lw", 1, 0, 3'b010, 32'h100, 0, 32'h8765_4321, 0, 4'b1111, 0);
    exp_q.push_back(32'hFFFF_FF80);
    run_access("lb", 1, 0, 3'b000, 32'h103, 0, 32'h8012_3456, 1, 4'b1000, 0);
    exp_q.push_back(32'h0000_0080);
    run_access("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h8012_3456, 0, 4'b1000, 0);
    exp_q.push_back(32'hFFFF_8001);
    run_access("lh", 1, 0, 3'b001, 32'h102, 0, 32'h8001_1234, 2, 4'b1100, 0);
    exp_q.push_back(32'h0000_F234);
    run_access("lhu", 1, 0, 3'b101, 32'h100, 0, 32'h8001_F234, 0, 4'b0011, 0);
    run_access("sh", 0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 0, 0, 4'b1100, 32'hBEEF_BEEF);
    check_val("sh_rdata_hold", Read_Data_o, 32'h0000_F234);
    run_access("sb_both", 1, 1, 3'b000, 32'h101, 32'h0000_00A5, 0, 1, 4'b0010, 32'hA5A5_A5A5);
    run_access("sw", 0, 1, 3'b011, 32'h304, 32'h1234_5678, 0, 0, 4'b1111, 32'h1234_5678);

    Mem_Ack_i = 1'b1;
    tick();
    Mem_Ack_i = 1'b0;
    check_val("stray_ack", 32'(state_dbg), 32'(S_IDLE));

    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h101;
    #1;
    check_val("mis_stall", 32'(Stall_o), 32'd0);
    tick();
    Mem_Read_i = 1'b0;
    #1;
    check_val("mis_flag", 32'(Misaligned_o), 32'd1);
    check_val("mis_req", 32'(Mem_Req_o), 32'd0);
    check_val("mis_rdata", Read_Data_o, 32'd0);
    tick();
    check_val("mis_pulse_end", 32'(Misaligned_o), 32'd0);
    check_val("mis_state", 32'(state_dbg), 32'(S_IDLE));

    exp_q.push_back(32'h0000_55AA);
    run_access("lhu2", 1, 0, 3'b101, 32'h102, 0, 32'h55AA_0000, 0, 4'b1100, 0);
    Mem_Read_i = 1'b1; Funct3_i = 3'b001; Address_i = 32'h103;
    tick();
    Mem_Read_i = 1'b0;
    check_val("mis_lh_flag", 32'(Misaligned_o), 32'd1);
    check_val("mis_lh_rdata", Read_Data_o, 32'd0);
    tick();

    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h300;
    tick();
    tick(); tick();
    check_val("abort_pre", 32'(state_dbg), 32'(S_ACCESS));
    reset = 1'b0;
    tick();
    reset = 1'b1; Mem_Read_i = 1'b0;
    #1;
    check_val("abort_req", 32'(Mem_Req_o), 32'd0);
    check_val("abort_state", 32'(state_dbg), 32'(S_IDLE));
    tick();
    Mem_Ack_i = 1'b1; Mem_Rdata_i = 32'hDEAD_BEEF;
    tick();
    Mem_Ack_i = 1'b0;
    check_val("late_ack_state", 32'(state_dbg), 32'(S_IDLE));
    check_val("late_ack_rdata", Read_Data_o, 32'd0);

    exp_q.push_back(32'h1111_2222);
    run_access("lw_pre_tmo", 1, 0, 3'b010, 32'h3FC, 0, 32'h1111_2222, 0, 4'b1111, 0);
    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h400;
    tick();
    cnt = 0;
    while (state_dbg == S_ACCESS && cnt < 24) begin
      cnt++;
      tick();
    end
    Mem_Read_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
    check_val("tmo_cycles", cnt, 16);
    check_val("tmo_state", 32'(state_dbg), 32'(S_DONE));
    check_val("tmo_rdata", Read_Data_o, 32'd0);
    check_val("tmo_berr", 32'(Bus_Error_o), 32'd1);
    tick(); tick();
    check_val("tmo_berr_sticky", 32'(Bus_Error_o), 32'd1);
`else
    check_val("notmo_wait", cnt, 24);
    check_val("notmo_state", 32'(state_dbg), 32'(S_ACCESS));
    check_val("notmo_berr", 32'(Bus_Error_o), 32'd0);
    check_val("notmo_rdata", Read_Data_o, 32'h1111_2222);
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_val("final_berr", 32'(Bus_Error_o), 32'd0);
    check_val("final_state", 32'(state_dbg), 32'(S_IDLE));
    check_val("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the number of ACCESS-state cycles without Mem_Ack_i before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port Mem_Read_i  in  1  load request from control.
REQ-005 SHALL have port Mem_Write_i  in  1  store request from control.
REQ-006 SHALL have port Funct3_i  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 SHALL have port Address_i  in  32  byte address, driven from the ALU result.
REQ-008 SHALL have port Write_Data_i  in  32  store data (rs2).
REQ-009 SHALL have port Read_Data_o  out  32  extended load data.
REQ-010 SHALL have port Stall_o  out  1  freeze PC/register write while an access is pending.
REQ-011 SHALL have port Misaligned_o  out  1  one-cycle misaligned-access flag.
REQ-012 SHALL have port Bus_Error_o  out  1  sticky timeout flag (LSU_TIMEOUT_EN only, else tied 0).
REQ-013 SHALL have memory ports Mem_Req_o out 1, Mem_We_o out 1, Mem_Addr_o out 32, Mem_Wdata_o out 32, Mem_Be_o out 4, Mem_Ack_i in 1, Mem_Rdata_i in 32.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 IDLE: on (Mem_Read_i|Mem_Write_i) with an aligned address, SHALL register address, byte enables, shifted write data, funct3 and direction, and go to ACCESS.
REQ-016 Alignment: half needs Address_i[0]=0, word needs Address_i[1:0]=00; funct3[1:0]=11 SHALL be treated as word.
REQ-017 Misaligned request in IDLE SHALL issue no memory access, pulse Misaligned_o for one cycle, set Read_Data_o=0, keep Stall_o=0, stay in IDLE.
REQ-018 Stall_o SHALL be combinational: 1 in IDLE with an aligned request present, 1 throughout ACCESS, 0 in DONE.
REQ-019 ACCESS: Mem_Req_o=1; Mem_We_o, Mem_Addr_o ({addr[31:2],2'b00}), Mem_Wdata_o, Mem_Be_o SHALL stay stable until the cycle Mem_Ack_i=1.
REQ-020 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; write data replicated into the selected lane(s).
REQ-021 On Mem_Ack_i in ACCESS, a load SHALL capture the selected lane, sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) into Read_Data_o, and go to DONE; minimum latency request-to-DONE is 2 cycles.
REQ-022 DONE SHALL last exactly one cycle with Read_Data_o valid, then return to IDLE without re-triggering.
REQ-023 Read_Data_o SHALL hold its value until the next completed load or misaligned event.
REQ-024 Simultaneous Mem_Read_i and Mem_Write_i SHALL be treated as a store.
REQ-025 Mem_Ack_i outside ACCESS SHALL be ignored.

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE, Read_Data_o=0, Misaligned_o=0, Bus_Error_o=0, Mem_Req_o=0, Mem_We_o=0, Mem_Be_o=0, Mem_Addr_o=0, Mem_Wdata_o=0, timeout counter=0.
REQ-027 Reset mid-ACCESS SHALL abort the access; Mem_Req_o SHALL be 0 the cycle after the reset edge, and a late Mem_Ack_i SHALL be ignored.

Configuration
REQ-028 Macro LSU_TIMEOUT_EN defined: SHALL count ACCESS cycles; reaching TIMEOUT_CYCLES without ack SHALL go to DONE with Read_Data_o=0 and set Bus_Error_o until reset.
REQ-029 LSU_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely, no counter SHALL be synthesized, Bus_Error_o=0.

Verification
REQ-030 LW at 0x100, Mem_Ack_i one cycle after request, Mem_Rdata_i=0x8765_4321 -> Mem_Be_o=1111, Stall_o high 2 cycles, Read_Data_o=0x8765_4321 in DONE.
REQ-031 LB at 0x103 and LBU at 0x103, Mem_Rdata_i=0x80xx_xxxx -> Mem_Be_o=1000, Read_Data_o=0xFFFF_FF80 and 0x0000_0080.
REQ-032 SH at 0x202, Write_Data_i=0x0000_BEEF -> Mem_Addr_o=0x200, Mem_Be_o=1100, Mem_Wdata_o[31:16]=0xBEEF, Mem_We_o=1.
REQ-033 LW at 0x101 -> Mem_Req_o stays 0, Misaligned_o=1 one cycle, Stall_o=0, Read_Data_o=0.
REQ-034 Ack delayed 5 cycles, reset asserted in cycle 3 of ACCESS -> IDLE, Mem_Req_o=0 next cycle, late ack ignored.
REQ-035 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> DONE after 16 ACCESS cycles, Bus_Error_o=1 until reset, Read_Data_o=0.
